// File: rtl/pacman_sound_pkg.sv
// Shared state encoding and default tone/duration constants for the Pac-Man sound sequencer.
package pacman_sound_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHIRP = 3'd1,
        ST_GAP   = 3'd2,
        ST_OV0   = 3'd3,
        ST_OV1   = 3'd4,
        ST_OV2   = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

    localparam int HALF_W = 17;

    localparam int unsigned DEF_HALF_EAT  = 25000;
    localparam int unsigned DEF_CHIRP_LEN = 5000000;
    localparam int unsigned DEF_GAP_LEN   = 2000000;
    localparam int unsigned DEF_NOTE_LEN  = 20000000;
    localparam int unsigned DEF_HALF_N0   = 38222;
    localparam int unsigned DEF_HALF_N1   = 47778;
    localparam int unsigned DEF_HALF_N2   = 63776;
    localparam int unsigned DEF_PEND_W    = 3;

    function automatic logic is_tone(input state_t s);
        return (s == ST_CHIRP) || (s == ST_OV0) || (s == ST_OV1) || (s == ST_OV2);
    endfunction

    function automatic logic is_busy(input state_t s);
        return (s == ST_GAP) || is_tone(s);
    endfunction

endpackage

// File: rtl/pacman_sound_seq_tone_gen.sv
// Square-wave generator: output toggles every 'half' cycles; load restarts the wave low.
module tone_gen
    import pacman_sound_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              load,
    input  logic [HALF_W-1:0] half,
    output logic              out
);

    logic [HALF_W-1:0] cnt_q;
    logic              out_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
            out_q <= 1'b0;
        end else if (load) begin
            cnt_q <= half - 1'b1;
            out_q <= 1'b0;
        end else if (!en) begin
            cnt_q <= '0;
            out_q <= 1'b0;
        end else if (cnt_q == '0) begin
            cnt_q <= half - 1'b1;
            out_q <= ~out_q;
        end else begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign out = out_q;

endmodule

// File: rtl/pacman_sound_seq.sv
// Bean-eaten chirps with a saturating pending queue, plus a one-shot game-over jingle.
module pacman_sound_seq
    import pacman_sound_pkg::*;
#(
    parameter int unsigned HALF_EAT  = DEF_HALF_EAT,
    parameter int unsigned CHIRP_LEN = DEF_CHIRP_LEN,
    parameter int unsigned GAP_LEN   = DEF_GAP_LEN,
    parameter int unsigned NOTE_LEN  = DEF_NOTE_LEN,
    parameter int unsigned HALF_N0   = DEF_HALF_N0,
    parameter int unsigned HALF_N1   = DEF_HALF_N1,
    parameter int unsigned HALF_N2   = DEF_HALF_N2,
    parameter int unsigned PEND_W    = DEF_PEND_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              eat,
    input  logic              over,
    output logic              beep,
    output logic              busy,
    output logic [PEND_W-1:0] pending
);

    localparam int unsigned MAX_CG  = (CHIRP_LEN > GAP_LEN) ? CHIRP_LEN : GAP_LEN;
    localparam int unsigned MAX_LEN = (MAX_CG > NOTE_LEN) ? MAX_CG : NOTE_LEN;
    localparam int          DUR_W   = $clog2(MAX_LEN + 1);

    localparam logic [DUR_W-1:0]  CHIRP_M1 = DUR_W'(CHIRP_LEN - 1);
    localparam logic [DUR_W-1:0]  GAP_M1   = DUR_W'(GAP_LEN - 1);
    localparam logic [DUR_W-1:0]  NOTE_M1  = DUR_W'(NOTE_LEN - 1);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    state_t              state_q, state_d;
    logic [DUR_W-1:0]    dur_q, dur_d, dur_len;
    logic [PEND_W-1:0]   pend_q, pend_d;
    logic                busy_q;
    logic                last, entering, tone_load, tone_en;
    logic [HALF_W-1:0]   half_d;

    // Next state and pending count; 'over' preempts everything in the chirp states.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        last    = (dur_q == '0);
        unique case (state_q)
            ST_IDLE: begin
                if (over) begin
                    state_d = ST_OV0;
                    pend_d  = '0;
                end else if (eat) begin
                    state_d = ST_CHIRP;
                end
            end
            ST_CHIRP: begin
                if (over) begin
                    state_d = ST_OV0;
                    pend_d  = '0;
                end else begin
                    if (eat && pend_q != PEND_MAX) pend_d = pend_q + 1'b1;
                    if (last) state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (over) begin
                    state_d = ST_OV0;
                    pend_d  = '0;
                end else if (last) begin
                    // An eat on the final gap cycle replaces the chirp being dequeued.
                    state_d = (pend_q != '0 || eat) ? ST_CHIRP : ST_IDLE;
                    if (pend_q != '0 && !eat) pend_d = pend_q - 1'b1;
                end else if (eat && pend_q != PEND_MAX) begin
                    pend_d = pend_q + 1'b1;
                end
            end
            ST_OV0:  if (last) state_d = ST_OV1;
            ST_OV1:  if (last) state_d = ST_OV2;
            ST_OV2:  if (last) state_d = ST_DONE;
            default: state_d = ST_DONE;
        endcase
    end

    always_comb begin
        dur_len = '0;
        half_d  = HALF_W'(HALF_EAT);
        unique case (state_d)
            ST_CHIRP: dur_len = CHIRP_M1;
            ST_GAP:   dur_len = GAP_M1;
            ST_OV0: begin dur_len = NOTE_M1; half_d = HALF_W'(HALF_N0); end
            ST_OV1: begin dur_len = NOTE_M1; half_d = HALF_W'(HALF_N1); end
            ST_OV2: begin dur_len = NOTE_M1; half_d = HALF_W'(HALF_N2); end
            default: dur_len = '0;
        endcase
        entering  = (state_d != state_q);
        dur_d     = entering ? dur_len : ((dur_q != '0) ? dur_q - 1'b1 : '0);
        tone_load = entering && is_tone(state_d);
        tone_en   = is_tone(state_d);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            dur_q   <= '0;
            pend_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dur_q   <= dur_d;
            pend_q  <= pend_d;
            busy_q  <= is_busy(state_d);
        end
    end

    tone_gen u_tone (
        .clk  (clk),
        .rst  (rst),
        .en   (tone_en),
        .load (tone_load),
        .half (half_d),
        .out  (beep)
    );

    assign busy    = busy_q;
    assign pending = pend_q;

endmodule

// File: tb/tb_pacman_sound_seq.sv
// Randomized bench for pacman_sound_seq against an elapsed-time behavioural model.
module tb_pacman_sound_seq;

    localparam int HE = 4, CL = 32, GL = 8, NL = 40;
    localparam int H0 = 5, H1 = 6, H2 = 8, PW = 3;
    localparam int PMAX = (1 << PW) - 1;

    localparam int M_IDLE = 0, M_CHIRP = 1, M_GAP = 2, M_OV0 = 3, M_OV1 = 4, M_OV2 = 5, M_DONE = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          eat = 1'b0;
    logic          over = 1'b0;
    logic          beep, busy;
    logic [PW-1:0] pending;

    always #5 clk = ~clk;

    pacman_sound_seq #(
        .HALF_EAT(HE), .CHIRP_LEN(CL), .GAP_LEN(GL), .NOTE_LEN(NL),
        .HALF_N0(H0), .HALF_N1(H1), .HALF_N2(H2), .PEND_W(PW)
    ) dut (
        .clk(clk), .rst(rst), .eat(eat), .over(over),
        .beep(beep), .busy(busy), .pending(pending)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Model: current mode, cycles elapsed since entering it, queued chirps.
    int m_mode = M_IDLE;
    int m_t    = 0;
    int m_pend = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit o, input bit e);
        if (!r) begin
            m_mode = M_IDLE; m_t = 0; m_pend = 0;
            return;
        end
        if (o && (m_mode == M_IDLE || m_mode == M_CHIRP || m_mode == M_GAP)) begin
            m_mode = M_OV0; m_t = 0; m_pend = 0;
            return;
        end
        case (m_mode)
            M_IDLE: if (e) begin m_mode = M_CHIRP; m_t = 0; end
            M_CHIRP: begin
                if (e && m_pend < PMAX) m_pend++;
                if (m_t == CL - 1) begin m_mode = M_GAP; m_t = 0; end
                else m_t++;
            end
            M_GAP: begin
                if (m_t == GL - 1) begin
                    m_t = 0;
                    if (m_pend > 0) begin
                        m_pend = m_pend - 1 + (e ? 1 : 0);
                        m_mode = M_CHIRP;
                    end else begin
                        m_mode = e ? M_CHIRP : M_IDLE;
                    end
                end else begin
                    if (e && m_pend < PMAX) m_pend++;
                    m_t++;
                end
            end
            M_OV0, M_OV1, M_OV2: begin
                if (m_t == NL - 1) begin m_mode++; m_t = 0; end
                else m_t++;
            end
            default: ;
        endcase
    endtask

    function automatic int exp_beep();
        int h;
        case (m_mode)
            M_CHIRP: h = HE;
            M_OV0:   h = H0;
            M_OV1:   h = H1;
            M_OV2:   h = H2;
            default: return 0;
        endcase
        return (m_t / h) % 2;
    endfunction

    function automatic int exp_busy();
        return (m_mode >= M_CHIRP && m_mode <= M_OV2) ? 1 : 0;
    endfunction

    task automatic cycle_run(input bit r, input bit o, input bit e);
        rst  = r;
        over = o;
        eat  = e;
        @(posedge clk);
        model_step(r, o, e);
        @(negedge clk);
        cyc++;
        chk("beep", 32'(beep), 32'(exp_beep()));
        chk("busy", 32'(busy), 32'(exp_busy()));
        chk("pending", 32'(pending), 32'(m_pend));
    endtask

    initial begin
        int eat_pct, over_at, rst_at;
        bit gap_hit, ov, r, e;

        cycle_run(1'b0, 1'b0, 1'b0);
        cycle_run(1'b0, 1'b1, 1'b1);

        for (int ep = 0; ep < 40; ep++) begin
            eat_pct = int'($urandom_range(0, 70));
            over_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 250)) : -1;
            rst_at  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(20, 350)) : -1;
            gap_hit = 1'($urandom_range(0, 1));
            ov      = 1'b0;
            cycle_run(1'b0, 1'b0, 1'b0);
            for (int c = 0; c < 400; c++) begin
                r = 1'b1;
                if (c == over_at) ov = 1'b1;
                if (c == rst_at) begin
                    r  = 1'b0;
                    ov = 1'b0;
                end
                e = ($urandom_range(0, 99) < 32'(eat_pct));
                if (gap_hit && m_mode == M_GAP && m_t == GL - 1) e = 1'b1;
                cycle_run(r, ov, e);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
